// File: rtl/dtcm_port_arbiter_pkg.sv
// rtl/dtcm_port_arbiter_pkg.sv - shared types and constants for the DTCM port arbiter
// Contents: DTCM geometry constants, read-return owner enum, request payload struct.
package tcm_pkg;

  localparam int DTCM_ADDR_W = 14;
  localparam int DTCM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } tcm_owner_e;

  typedef struct packed {
    logic                     we;
    logic [DTCM_DATA_W/8-1:0] be;
    logic [DTCM_ADDR_W-1:0]   addr;
    logic [DTCM_DATA_W-1:0]   wdata;
  } tcm_req_t;

endpackage

// File: rtl/dtcm_port_arbiter_if.sv
// rtl/dtcm_port_arbiter_if.sv - CPU, host and SRAM signal bundle of the DTCM arbiter
// Groups: cpu_* (req/gnt + load return), host_* (valid/ready + read return),
//         mem_* (SRAM control out, mem_rdata in).
// Modports: slave = arbiter view, master = environment view (CPU, host, SRAM).
interface dtcm_port_arbiter_if #(
  parameter int ADDR_W = tcm_pkg::DTCM_ADDR_W,
  parameter int DATA_W = tcm_pkg::DTCM_DATA_W
) ();

  localparam int BE_W = DATA_W / 8;

  logic              cpu_req;
  logic              cpu_we;
  logic [BE_W-1:0]   cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              host_valid;
  logic              host_we;
  logic [BE_W-1:0]   host_be;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_valid, host_we, host_be, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_valid, host_we, host_be, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/tcm_starve_counter.sv
// rtl/tcm_starve_counter.sv - host starvation counter with forced-grant flag
// Ports: clk_i, rst_ni (async, active-low), host_valid_i, host_ready_i,
//        cnt_o (consecutive denied host cycles, saturating), force_o (host must win now).
module tcm_starve_counter #(
  parameter int LIMIT = 8,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             host_valid_i,
  input  logic             host_ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             force_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (host_ready_i) begin
      cnt_d = '0;
    end else if (host_valid_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on the registered count, so it cannot loop back through host_ready.
  assign force_o = host_valid_i & (cnt_q == LIMIT_C);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/dtcm_port_arbiter.sv
// rtl/dtcm_port_arbiter.sv - CPU/host arbiter for the single-port DTCM SRAM
// Ports: clk, reset (async, active-low), bus (dtcm_port_arbiter_if.slave: CPU req/gnt,
//        host valid/ready, read returns, SRAM control), starve_cnt (debug count).
// CPU wins by default; after STARVE_LIMIT denied host cycles the host takes one slot.
module dtcm_port_arbiter
  import tcm_pkg::*;
#(
  parameter int ADDR_W       = DTCM_ADDR_W,
  parameter int DATA_W       = DTCM_DATA_W,
  parameter int STARVE_LIMIT = 8,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  dtcm_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] starve_cnt
);

  logic       force_host;
  logic       host_ready;
  logic       cpu_gnt;
  tcm_owner_e rd_owner_q;
  tcm_owner_e rd_owner_d;

  tcm_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk_i        (clk),
    .rst_ni       (reset),
    .host_valid_i (bus.host_valid),
    .host_ready_i (host_ready),
    .cnt_o        (starve_cnt),
    .force_o      (force_host)
  );

  // Gating with reset keeps the SRAM untouched while reset is held low.
  assign host_ready = reset & bus.host_valid & (~bus.cpu_req | force_host);
  assign cpu_gnt    = reset & bus.cpu_req & ~host_ready;

  assign bus.host_ready = host_ready;
  assign bus.cpu_gnt    = cpu_gnt;

  // Payload defaults to the CPU side so the SRAM inputs toggle less when idle.
  assign bus.mem_en    = cpu_gnt | host_ready;
  assign bus.mem_we    = host_ready ? bus.host_we    : bus.cpu_we;
  assign bus.mem_be    = host_ready ? bus.host_be    : bus.cpu_be;
  assign bus.mem_addr  = host_ready ? bus.host_addr  : bus.cpu_addr;
  assign bus.mem_wdata = host_ready ? bus.host_wdata : bus.cpu_wdata;

  // Remembers who issued the read so next cycle's SRAM data goes to the right side.
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (host_ready && !bus.host_we) begin
      rd_owner_d = OWN_HOST;
    end else if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.cpu_rvalid  = (rd_owner_q == OWN_CPU);
  assign bus.host_rvalid = (rd_owner_q == OWN_HOST);
  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.host_rdata  = bus.mem_rdata;

  // A waiting host request must stay up, unchanged, until it is accepted.
  a_host_hold : assert property (
    @(posedge clk) disable iff (!reset)
    (bus.host_valid && !host_ready) |=>
      (bus.host_valid &&
       $stable({bus.host_we, bus.host_be, bus.host_addr, bus.host_wdata}))
  );

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// tb/tb_dtcm_port_arbiter.sv - self-checking bench for dtcm_port_arbiter
module tb_dtcm_port_arbiter;
  import tcm_pkg::*;

  localparam int LIMIT = 8;
  localparam int DEPTH = 1 << DTCM_ADDR_W;

  logic       clk;
  logic       reset;
  logic [3:0] starve_cnt;

  int vectors;
  int errors;

  dtcm_port_arbiter_if #(.ADDR_W(DTCM_ADDR_W), .DATA_W(DTCM_DATA_W)) bus ();

  dtcm_port_arbiter #(
    .ADDR_W       (DTCM_ADDR_W),
    .DATA_W       (DTCM_DATA_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .starve_cnt (starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM behind the arbiter: one-cycle read latency, byte-masked writes.
  logic [31:0] sram [0:DEPTH-1];
  logic [31:0] sram_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) sram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end else begin
        sram_q <= sram[bus.mem_addr];
      end
    end
  end
  assign bus.mem_rdata = sram_q;

  // Reference model: memory contents in grant order, length of the current host
  // wait, and which side expects data on the next cycle (0 none, 1 cpu, 2 host).
  logic [31:0] shadow [0:DEPTH-1];
  int          m_starve;
  int          m_pend;
  logic [31:0] m_pend_data;
  logic        last_c;
  logic        last_h;

  function automatic logic exp_host();
    return reset && bus.host_valid && (!bus.cpu_req || (m_starve >= LIMIT));
  endfunction

  function automatic logic exp_cpu();
    return reset && bus.cpu_req && !exp_host();
  endfunction

  task automatic shadow_write(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic model_advance();
    logic h;
    logic c;
    h = exp_host();
    c = exp_cpu();
    m_pend = 0;
    if (h && !bus.host_we) begin
      m_pend = 2;
      m_pend_data = shadow[bus.host_addr];
    end else if (c && !bus.cpu_we) begin
      m_pend = 1;
      m_pend_data = shadow[bus.cpu_addr];
    end
    if (h && bus.host_we) shadow_write(bus.host_addr, bus.host_be, bus.host_wdata);
    else if (c && bus.cpu_we) shadow_write(bus.cpu_addr, bus.cpu_be, bus.cpu_wdata);
    if (h) m_starve = 0;
    else if (bus.host_valid) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    if (!reset) begin
      m_starve = 0;
      m_pend = 0;
    end
    last_h = h;
    last_c = c;
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    sram[a] = d;
    shadow[a] = d;
  endtask

  task automatic set_idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_be = 4'h0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_valid = 1'b0; bus.host_we = 1'b0; bus.host_be = 4'h0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic cpu_drive(input tcm_req_t r);
    bus.cpu_req = 1'b1; bus.cpu_we = r.we; bus.cpu_be = r.be; bus.cpu_addr = r.addr; bus.cpu_wdata = r.wdata;
  endtask

  task automatic host_drive(input tcm_req_t r);
    bus.host_valid = 1'b1; bus.host_we = r.we; bus.host_be = r.be; bus.host_addr = r.addr; bus.host_wdata = r.wdata;
  endtask

  task automatic test_reset();
    tcm_req_t r;
    r = '{we: 1'b0, be: 4'hF, addr: 14'h10, wdata: 32'h0};
    reset = 1'b0;
    cpu_drive(r);
    host_drive(r);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got %b want 0", bus.cpu_gnt); end
    vectors++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL reset_host_ready got %b want 0", bus.host_ready); end
    vectors++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b want 0", bus.mem_en); end
    vectors++; if (bus.cpu_rvalid !== 1'b0 || bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b want 00", bus.cpu_rvalid, bus.host_rvalid); end
    vectors++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_starve got %0d want 0", starve_cnt); end
    @(posedge clk);
    #1;
    set_idle();
    reset = 1'b1;
    m_starve = 0;
    m_pend = 0;
    tick();
  endtask

  task automatic test_cpu_only();
    preload(14'h10, 32'hDEADBEEF);
    cpu_drive('{we: 1'b0, be: 4'hF, addr: 14'h10, wdata: 32'h0});
    @(negedge clk);
    vectors++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL cpu_only_gnt got %b want 1", bus.cpu_gnt); end
    vectors++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h10) begin errors++; $display("FAIL cpu_only_mem got en=%b we=%b addr=%h want 1 0 0010", bus.mem_en, bus.mem_we, bus.mem_addr); end
    tick();
    set_idle();
    @(negedge clk);
    vectors++; if (bus.cpu_rvalid !== 1'b1) begin errors++; $display("FAIL cpu_only_rvalid got %b want 1", bus.cpu_rvalid); end
    vectors++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_only_rdata got %h want deadbeef", bus.cpu_rdata); end
    vectors++; if (bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_only_host_rvalid got %b want 0", bus.host_rvalid); end
    tick();
  endtask

  task automatic test_contention();
    logic want_h;
    cpu_drive('{we: 1'b0, be: 4'hF, addr: 14'h30, wdata: 32'h0});
    host_drive('{we: 1'b0, be: 4'hF, addr: 14'h31, wdata: 32'h0});
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      want_h = (k == 9) || (k == 18);
      vectors++; if (bus.host_ready !== want_h) begin errors++; $display("FAIL contention_host_ready cycle %0d got %b want %b", k, bus.host_ready, want_h); end
      vectors++; if (bus.cpu_gnt !== !want_h) begin errors++; $display("FAIL contention_cpu_gnt cycle %0d got %b want %b", k, bus.cpu_gnt, !want_h); end
      vectors++; if (starve_cnt !== 4'((k - 1) % 9)) begin errors++; $display("FAIL contention_starve cycle %0d got %0d want %0d", k, starve_cnt, (k - 1) % 9); end
      tick();
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    vectors++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL contention_release got %b want 1", bus.host_ready); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_interleaved();
    preload(14'h4, 32'h11112222);
    preload(14'h8, 32'h33334444);
    cpu_drive('{we: 1'b0, be: 4'hF, addr: 14'h4, wdata: 32'h0});
    @(negedge clk);
    vectors++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL inter_cpu_gnt got %b want 1", bus.cpu_gnt); end
    tick();
    set_idle();
    host_drive('{we: 1'b0, be: 4'hF, addr: 14'h8, wdata: 32'h0});
    @(negedge clk);
    vectors++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL inter_host_ready got %b want 1", bus.host_ready); end
    vectors++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h11112222) begin errors++; $display("FAIL inter_cpu_data got v=%b d=%h want 1 11112222", bus.cpu_rvalid, bus.cpu_rdata); end
    tick();
    set_idle();
    @(negedge clk);
    vectors++; if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 32'h33334444) begin errors++; $display("FAIL inter_host_data got v=%b d=%h want 1 33334444", bus.host_rvalid, bus.host_rdata); end
    vectors++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL inter_cpu_rvalid_after got %b want 0", bus.cpu_rvalid); end
    tick();
  endtask

  task automatic test_host_write();
    preload(14'h20, 32'hCAFEF00D);
    host_drive('{we: 1'b1, be: 4'b0011, addr: 14'h20, wdata: 32'h5A5A5A5A});
    @(negedge clk);
    vectors++; if (bus.host_ready !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011) begin errors++; $display("FAIL hwrite_issue got rdy=%b we=%b be=%b want 1 1 0011", bus.host_ready, bus.mem_we, bus.mem_be); end
    vectors++; if (bus.mem_wdata !== 32'h5A5A5A5A || bus.mem_addr !== 14'h20) begin errors++; $display("FAIL hwrite_payload got %h@%h want 5a5a5a5a@0020", bus.mem_wdata, bus.mem_addr); end
    tick();
    set_idle();
    cpu_drive('{we: 1'b0, be: 4'hF, addr: 14'h20, wdata: 32'h0});
    @(negedge clk);
    vectors++; if (bus.cpu_rvalid !== 1'b0 || bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL hwrite_no_rvalid got %b%b want 00", bus.cpu_rvalid, bus.host_rvalid); end
    tick();
    set_idle();
    @(negedge clk);
    vectors++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hCAFE5A5A) begin errors++; $display("FAIL hwrite_readback got v=%b d=%h want 1 cafe5a5a", bus.cpu_rvalid, bus.cpu_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    cpu_drive('{we: 1'b0, be: 4'hF, addr: 14'h10, wdata: 32'h0});
    @(negedge clk);
    vectors++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got %b want 1", bus.cpu_gnt); end
    tick();
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    vectors++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_in_reset got %b want 0", bus.cpu_rvalid); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (bus.cpu_rvalid !== 1'b0 || bus.host_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_after got %b%b want 00", bus.cpu_rvalid, bus.host_rvalid); end
    tick();
  endtask

  task automatic test_random();
    tcm_req_t r;
    logic eh;
    logic ec;
    last_c = 1'b1;
    last_h = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!bus.cpu_req || last_c) begin
        r.we = 1'($urandom_range(0, 1)); r.be = 4'($urandom); r.addr = 14'h40 + 14'($urandom_range(0, 7)); r.wdata = $urandom;
        if ($urandom_range(0, 3) != 0) cpu_drive(r);
        else bus.cpu_req = 1'b0;
      end
      if (!bus.host_valid || last_h) begin
        r.we = 1'($urandom_range(0, 1)); r.be = 4'($urandom); r.addr = 14'h40 + 14'($urandom_range(0, 7)); r.wdata = $urandom;
        if ($urandom_range(0, 1) != 0) host_drive(r);
        else bus.host_valid = 1'b0;
      end
      @(negedge clk);
      eh = exp_host();
      ec = exp_cpu();
      vectors++; if (bus.host_ready !== eh || bus.cpu_gnt !== ec) begin errors++; $display("FAIL rand_grant n=%0d got h=%b c=%b want h=%b c=%b", n, bus.host_ready, bus.cpu_gnt, eh, ec); end
      vectors++; if (bus.mem_en !== (eh | ec)) begin errors++; $display("FAIL rand_mem_en n=%0d got %b want %b", n, bus.mem_en, eh | ec); end
      if (eh) begin
        vectors++; if (bus.mem_addr !== bus.host_addr || bus.mem_we !== bus.host_we) begin errors++; $display("FAIL rand_mux_host n=%0d got %h/%b want %h/%b", n, bus.mem_addr, bus.mem_we, bus.host_addr, bus.host_we); end
      end else if (ec) begin
        vectors++; if (bus.mem_addr !== bus.cpu_addr || bus.mem_we !== bus.cpu_we) begin errors++; $display("FAIL rand_mux_cpu n=%0d got %h/%b want %h/%b", n, bus.mem_addr, bus.mem_we, bus.cpu_addr, bus.cpu_we); end
      end
      vectors++; if (starve_cnt !== 4'(m_starve)) begin errors++; $display("FAIL rand_starve n=%0d got %0d want %0d", n, starve_cnt, m_starve); end
      vectors++; if (bus.cpu_rvalid !== (m_pend == 1) || bus.host_rvalid !== (m_pend == 2)) begin errors++; $display("FAIL rand_rvalid n=%0d got %b%b want owner %0d", n, bus.cpu_rvalid, bus.host_rvalid, m_pend); end
      if (m_pend == 1) begin
        vectors++; if (bus.cpu_rdata !== m_pend_data) begin errors++; $display("FAIL rand_cpu_rdata n=%0d got %h want %h", n, bus.cpu_rdata, m_pend_data); end
      end else if (m_pend == 2) begin
        vectors++; if (bus.host_rdata !== m_pend_data) begin errors++; $display("FAIL rand_host_rdata n=%0d got %h want %h", n, bus.host_rdata, m_pend_data); end
      end
      tick();
    end
    bus.cpu_req = 1'b0;
    tick();
    set_idle();
    tick();
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    m_starve = 0;
    m_pend = 0;
    m_pend_data = '0;
    last_c = 1'b0;
    last_h = 1'b0;
    sram_q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = $urandom;
      shadow[i] = sram[i];
    end
    set_idle();
    reset = 1'b0;
    test_reset();
    test_cpu_only();
    test_contention();
    test_interleaved();
    test_host_write();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
